// File: rtl/instr_encoder_if.sv
// Request and instruction-memory bundle for the RV32I encoder/loader.
// The requester holds the master side; the encoder holds the slave side.
interface instr_encoder_if #(
    parameter int DEPTH = 64
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op_sel;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [12:0]   imm;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [CW-1:0] word_cnt;
    logic          err;
    logic          full;

    modport master (
        output clear,
        output in_valid,
        output op_sel,
        output rd,
        output rs1,
        output rs2,
        output imm,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  word_cnt,
        input  err,
        input  full
    );

    modport slave (
        input  clear,
        input  in_valid,
        input  op_sel,
        input  rd,
        input  rs1,
        input  rs2,
        input  imm,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output word_cnt,
        output err,
        output full
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder and loader: symbolic ops in, encoded words
// written sequentially into instruction memory, two cycles per word.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DEPTH     = 64
) (
    input  logic clk,
    input  logic rst,
    instr_encoder_if.slave enc
);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;
    localparam logic [6:0] OP_BRAN = 7'b1100011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FULL
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_mem_we;
    logic          w_mem_we_nxt;
    logic [31:0]   r_mem_addr;
    logic [31:0]   w_mem_addr_nxt;
    logic [31:0]   r_mem_wdata;
    logic [31:0]   w_mem_wdata_nxt;
    logic [CW-1:0] r_word_cnt;
    logic [CW-1:0] w_word_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic          r_err;
    logic          w_err_nxt;

    logic          w_in_ready;
    logic          w_accept;
    logic [31:0]   w_word;
    logic          w_legal;
    logic          w_fits12;
    logic [12:0]   w_imm;

    assign w_imm      = enc.imm;
    assign w_in_ready = (r_state == IDLE) && !enc.clear;
    assign w_accept   = enc.in_valid && w_in_ready;
    assign w_cnt_inc  = r_word_cnt + CW'(1);

    // A 13-bit value fits the 12-bit signed field when its top two bits agree.
    assign w_fits12 = (w_imm[12] == w_imm[11]);

    always_comb begin
        w_word  = '0;
        w_legal = 1'b0;
        case (enc.op_sel)
            4'd0: begin
                w_word  = {F7_ZERO, enc.rs2, enc.rs1, 3'b000, enc.rd, OP_R};
                w_legal = 1'b1;
            end
            4'd1: begin
                w_word  = {F7_SUB, enc.rs2, enc.rs1, 3'b000, enc.rd, OP_R};
                w_legal = 1'b1;
            end
            4'd2: begin
                w_word  = {F7_ZERO, enc.rs2, enc.rs1, 3'b111, enc.rd, OP_R};
                w_legal = 1'b1;
            end
            4'd3: begin
                w_word  = {F7_ZERO, enc.rs2, enc.rs1, 3'b110, enc.rd, OP_R};
                w_legal = 1'b1;
            end
            4'd4: begin
                w_word  = {F7_ZERO, enc.rs2, enc.rs1, 3'b010, enc.rd, OP_R};
                w_legal = 1'b1;
            end
            4'd5: begin
                w_word  = {w_imm[11:0], enc.rs1, 3'b000, enc.rd, OP_IMM};
                w_legal = w_fits12;
            end
            4'd6: begin
                w_word  = {w_imm[11:0], enc.rs1, 3'b010, enc.rd, OP_LOAD};
                w_legal = w_fits12;
            end
            4'd7: begin
                w_word  = {w_imm[11:5], enc.rs2, enc.rs1, 3'b010,
                           w_imm[4:0], OP_STOR};
                w_legal = w_fits12;
            end
            4'd8: begin
                w_word  = {w_imm[12], w_imm[10:5], enc.rs2, enc.rs1, 3'b000,
                           w_imm[4:1], w_imm[11], OP_BRAN};
                w_legal = !w_imm[0];
            end
            4'd9: begin
                w_word  = {w_imm[12], w_imm[10:5], enc.rs2, enc.rs1, 3'b001,
                           w_imm[4:1], w_imm[11], OP_BRAN};
                w_legal = !w_imm[0];
            end
            default: begin
                w_word  = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_word_cnt_nxt  = r_word_cnt;
        w_err_nxt       = r_err;
        // The strobe of a WRITE cycle is already on the bus, so clear only
        // has to rewind the bookkeeping.
        if (enc.clear) begin
            w_state_nxt    = IDLE;
            w_mem_addr_nxt = BASE_ADDR;
            w_word_cnt_nxt = '0;
            w_err_nxt      = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            w_state_nxt     = WRITE;
                            w_mem_we_nxt    = 1'b1;
                            w_mem_wdata_nxt = w_word;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    w_mem_addr_nxt = r_mem_addr + 32'd4;
                    w_word_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CW'(DEPTH)) begin
                        w_state_nxt = FULL;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                FULL: begin
                    w_state_nxt = FULL;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE_ADDR;
            r_mem_wdata <= '0;
            r_word_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign enc.in_ready  = w_in_ready;
    assign enc.mem_we    = r_mem_we;
    assign enc.mem_addr  = r_mem_addr;
    assign enc.mem_wdata = r_mem_wdata;
    assign enc.word_cnt  = r_word_cnt;
    assign enc.err       = r_err;
    assign enc.full      = (r_state == FULL);
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a DEPTH=64 unit for encoding and
// handshake timing, and a DEPTH=2 unit for the FULL/clear boundary.
module tb_instr_encoder;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    instr_encoder_if #(.DEPTH(64)) a_if ();
    instr_encoder_if #(.DEPTH(2))  b_if ();

    instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(64)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .enc (a_if.slave)
    );

    instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(2)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .enc (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue_a(input logic [3:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [12:0] imm);
        int guard;
        guard = 0;
        while (!a_if.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("a_ready_timeout", 32'd0, 32'd1);
        a_if.op_sel   = op;
        a_if.rd       = rd;
        a_if.rs1      = rs1;
        a_if.rs2      = rs2;
        a_if.imm      = imm;
        a_if.in_valid = 1'b1;
        @(posedge clk);
        #1 a_if.in_valid = 1'b0;
    endtask

    task automatic issue_b(input logic [3:0] op);
        int guard;
        guard = 0;
        while (!b_if.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("b_ready_timeout", 32'd0, 32'd1);
        b_if.op_sel   = op;
        b_if.rd       = 5'd1;
        b_if.rs1      = 5'd2;
        b_if.rs2      = 5'd3;
        b_if.imm      = 13'd0;
        b_if.in_valid = 1'b1;
        @(posedge clk);
        #1 b_if.in_valid = 1'b0;
    endtask

    task automatic check_write_a(input string tag, input logic [31:0] addr,
                                 input logic [31:0] data);
        @(negedge clk);
        chk({tag, "_we"}, 32'(a_if.mem_we), 32'd1);
        chk({tag, "_addr"}, a_if.mem_addr, addr);
        chk({tag, "_data"}, a_if.mem_wdata, data);
        chk({tag, "_busy"}, 32'(a_if.in_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_we_off"}, 32'(a_if.mem_we), 32'd0);
        chk({tag, "_ready"}, 32'(a_if.in_ready), 32'd1);
    endtask

    task automatic check_reject_a(input string tag, input logic [31:0] cnt);
        @(negedge clk);
        chk({tag, "_no_we"}, 32'(a_if.mem_we), 32'd0);
        chk({tag, "_err"}, 32'(a_if.err), 32'd1);
        chk({tag, "_cnt"}, 32'(a_if.word_cnt), cnt);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        a_if.clear = 1'b0; a_if.in_valid = 1'b0; a_if.op_sel = '0;
        a_if.rd = '0; a_if.rs1 = '0; a_if.rs2 = '0; a_if.imm = '0;
        b_if.clear = 1'b0; b_if.in_valid = 1'b0; b_if.op_sel = '0;
        b_if.rd = '0; b_if.rs1 = '0; b_if.rs2 = '0; b_if.imm = '0;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(a_if.mem_we), 32'd0);
        chk("rst_addr", a_if.mem_addr, 32'h0);
        chk("rst_wdata", a_if.mem_wdata, 32'h0);
        chk("rst_cnt", 32'(a_if.word_cnt), 32'd0);
        chk("rst_err", 32'(a_if.err), 32'd0);
        chk("rst_full", 32'(a_if.full), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(a_if.in_ready), 32'd1);

        issue_a(4'd0, 5'd3, 5'd1, 5'd2, 13'd0);
        check_write_a("add", 32'h0, 32'h002081B3);
        chk("add_cnt", 32'(a_if.word_cnt), 32'd1);

        issue_a(4'd1, 5'd3, 5'd1, 5'd2, 13'd0);
        check_write_a("sub", 32'h4, 32'h402081B3);
        issue_a(4'd6, 5'd5, 5'd2, 5'd0, 13'd8);
        check_write_a("lw", 32'h8, 32'h00812283);

        issue_a(4'd7, 5'd0, 5'd2, 5'd6, 13'd12);
        check_write_a("sw", 32'hC, 32'h00612623);
        issue_a(4'd8, 5'd0, 5'd1, 5'd2, -13'sd8);
        check_write_a("beq", 32'h10, 32'hFE208CE3);
        issue_a(4'd3, 5'd7, 5'd8, 5'd9, 13'd0);
        check_write_a("or", 32'h14, 32'h009463B3);
        chk("cnt6", 32'(a_if.word_cnt), 32'd6);

        issue_a(4'd12, 5'd1, 5'd1, 5'd1, 13'd0);
        check_reject_a("ill_op", 32'd6);
        issue_a(4'd5, 5'd1, 5'd1, 5'd0, 13'd3000);
        check_reject_a("addi_rng", 32'd6);
        issue_a(4'd9, 5'd0, 5'd1, 5'd2, 13'd5);
        check_reject_a("bne_odd", 32'd6);
        chk("err_addr", a_if.mem_addr, 32'h18);

        // clear beats a simultaneous request
        a_if.clear = 1'b1;
        a_if.in_valid = 1'b1;
        a_if.op_sel = 4'd0;
        #1 chk("clr_ready", 32'(a_if.in_ready), 32'd0);
        @(posedge clk);
        #1 a_if.clear = 1'b0;
        a_if.in_valid = 1'b0;
        @(negedge clk);
        chk("clr_no_we", 32'(a_if.mem_we), 32'd0);
        chk("clr_err", 32'(a_if.err), 32'd0);
        chk("clr_cnt", 32'(a_if.word_cnt), 32'd0);
        chk("clr_addr", a_if.mem_addr, 32'h0);

        issue_b(4'd0);
        @(negedge clk);
        chk("b1_we", 32'(b_if.mem_we), 32'd1);
        chk("b1_addr", b_if.mem_addr, 32'h0);
        @(negedge clk);
        issue_b(4'd2);
        @(negedge clk);
        chk("b2_we", 32'(b_if.mem_we), 32'd1);
        chk("b2_addr", b_if.mem_addr, 32'h4);
        @(negedge clk);
        chk("b_full", 32'(b_if.full), 32'd1);
        chk("b_full_ready", 32'(b_if.in_ready), 32'd0);
        b_if.op_sel = 4'd4;
        b_if.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b_held_we", 32'(b_if.mem_we), 32'd0);
        end
        chk("b_held_cnt", 32'(b_if.word_cnt), 32'd2);
        chk("b_held_full", 32'(b_if.full), 32'd1);
        b_if.in_valid = 1'b0;
        b_if.clear = 1'b1;
        @(posedge clk);
        #1 b_if.clear = 1'b0;
        @(negedge clk);
        chk("b_clr_cnt", 32'(b_if.word_cnt), 32'd0);
        chk("b_clr_addr", b_if.mem_addr, 32'h0);
        chk("b_clr_err", 32'(b_if.err), 32'd0);
        chk("b_clr_full", 32'(b_if.full), 32'd0);
        chk("b_clr_ready", 32'(b_if.in_ready), 32'd1);

        issue_a(4'd4, 5'd4, 5'd5, 5'd6, 13'd0);
        check_write_a("slt", 32'h0, 32'h0062A233);
        issue_a(4'd2, 5'd3, 5'd1, 5'd2, 13'd0);
        @(negedge clk);
        chk("mid_we", 32'(a_if.mem_we), 32'd1);
        rst = 1'b1;
        #1 chk("rst_mid_we", 32'(a_if.mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_cnt", 32'(a_if.word_cnt), 32'd0);
        chk("rst_mid_addr", a_if.mem_addr, 32'h0);
        chk("rst_mid_ready", 32'(a_if.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
